// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, state encoding and counter helper for the hazard_ctrl pipeline sequencer.
// Optional build macro used by the controller: HAZARD_CTRL_CSR_SERIALIZE_EN.
package hazard_ctrl_pkg;

    localparam int OPLEN = 7;
    localparam int XADDR = 5;

    localparam logic [OPLEN-1:0] L_OP      = 7'b0000011;
    localparam logic [OPLEN-1:0] SYSTEM_OP = 7'b1110011;

    localparam int FLUSH_CYCLES_DEF     = 2;
    localparam int LOAD_USE_BUBBLES_DEF = 1;
    localparam int CSR_DRAIN_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        HC_RUN        = 3'd0,
        HC_LOAD_STALL = 3'd1,
        HC_FLUSH      = 3'd2,
        HC_MEM_WAIT   = 3'd3,
        HC_CSR_DRAIN  = 3'd4
    } hc_state_e;

    // The cycle that detects the event is the first of n, so the counter covers n-1 more.
    function automatic logic [2:0] cnt_init(input int n);
        return (n > 1) ? 3'(n - 2) : 3'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use compare between the load in EX and the source operands in ID.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [OPLEN-1:0] i_ex_opcode,
    input  logic [XADDR-1:0] i_ex_rd_addr,
    input  logic             i_ex_rd_wr_en,
    input  logic [XADDR-1:0] i_id_rs1_addr,
    input  logic [XADDR-1:0] i_id_rs2_addr,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    output logic             o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_id_use_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
    assign rs2_hit    = i_id_use_rs2 & (i_id_rs2_addr == i_ex_rd_addr);
    assign o_load_use = (i_ex_opcode == L_OP) & i_ex_rd_wr_en & (i_ex_rd_addr != '0)
                        & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, jump flush, memory-wait freeze.
// Define HAZARD_CTRL_CSR_SERIALIZE_EN to hold SYSTEM instructions in ID until the pipe drains.
//
// state         | meaning
// HC_RUN        | normal flow, events detected here
// HC_LOAD_STALL | extra load-use bubbles, front end held
// HC_FLUSH      | extra cycles discarding wrong-path instructions
// HC_MEM_WAIT   | data memory busy, whole pipe frozen
// HC_CSR_DRAIN  | SYSTEM instruction held in ID while older ones retire
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES     = FLUSH_CYCLES_DEF,
    parameter int LOAD_USE_BUBBLES = LOAD_USE_BUBBLES_DEF,
    parameter int CSR_DRAIN_CYCLES = CSR_DRAIN_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [OPLEN-1:0] i_id_opcode,
    input  logic [XADDR-1:0] i_id_rs1_addr,
    input  logic [XADDR-1:0] i_id_rs2_addr,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [OPLEN-1:0] i_ex_opcode,
    input  logic [XADDR-1:0] i_ex_rd_addr,
    input  logic             i_ex_rd_wr_en,
    input  logic             i_ex_pc_jump,
    input  logic             i_mem_busy,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic [2:0]       o_state
);

    hc_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       hold_all;
    logic       hold_front;
    logic       flush_both;
    logic       csr_hazard;

`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
    logic release_q, release_d;
    assign csr_hazard = (i_id_opcode == SYSTEM_OP) & ~release_q;
`else
    logic unused_id_opcode;
    assign unused_id_opcode = ^i_id_opcode;
    assign csr_hazard       = 1'b0;
`endif

    hazard_detect u_detect (
        .i_ex_opcode   (i_ex_opcode),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .i_ex_rd_wr_en (i_ex_rd_wr_en),
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .o_load_use    (load_use)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_all   = 1'b0;
        hold_front = 1'b0;
        flush_both = 1'b0;
`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
        release_d  = 1'b0;
`endif
        if (i_mem_busy && state_q != HC_MEM_WAIT) begin
            hold_all = 1'b1;
            state_d  = HC_MEM_WAIT;
            cnt_d    = 3'd0;
        end else if (i_ex_pc_jump && state_q != HC_MEM_WAIT) begin
            flush_both = 1'b1;
            state_d    = (FLUSH_CYCLES > 1) ? HC_FLUSH : HC_RUN;
            cnt_d      = cnt_init(FLUSH_CYCLES);
        end else begin
            case (state_q)
                HC_RUN: begin
                    if (load_use) begin
                        hold_front = 1'b1;
                        state_d    = (LOAD_USE_BUBBLES > 1) ? HC_LOAD_STALL : HC_RUN;
                        cnt_d      = cnt_init(LOAD_USE_BUBBLES);
                    end else if (csr_hazard) begin
                        hold_front = 1'b1;
                        state_d    = (CSR_DRAIN_CYCLES > 1) ? HC_CSR_DRAIN : HC_RUN;
                        cnt_d      = cnt_init(CSR_DRAIN_CYCLES);
`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
                        release_d  = (CSR_DRAIN_CYCLES <= 1);
`endif
                    end
                end
                HC_MEM_WAIT: begin
                    hold_all = i_mem_busy;
                    if (!i_mem_busy) state_d = HC_RUN;
                end
                // Younger instructions are being discarded, so load-use is irrelevant here.
                HC_FLUSH: begin
                    flush_both = 1'b1;
                    if (cnt_q == 3'd0) state_d = HC_RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                HC_LOAD_STALL, HC_CSR_DRAIN: begin
                    hold_front = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = HC_RUN;
`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
                        release_d = (state_q == HC_CSR_DRAIN);
`endif
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = HC_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HC_RUN;
            cnt_q   <= 3'd0;
`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
            release_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef HAZARD_CTRL_CSR_SERIALIZE_EN
            release_q <= release_d;
`endif
        end
    end

    // Flush always wins: stall_id is never raised together with flush_id.
    assign o_stall_if  = ~i_rst & (hold_all | hold_front);
    assign o_stall_id  = ~i_rst & (hold_all | hold_front);
    assign o_stall_ex  = ~i_rst & hold_all;
    assign o_stall_mem = ~i_rst & hold_all;
    assign o_flush_id  = ~i_rst & flush_both;
    assign o_flush_ex  = ~i_rst & (flush_both | hold_front);
    assign o_state     = i_rst ? HC_RUN : state_q;

endmodule
